msg_asm_stream: RTL and testbench
=================================

MSG_ASM_STREAM -- requirements
Module: msg_asm_stream

Interface
REQ-001 SHALL provide parameter WORD_SIZE, default 8, bits per input word.
REQ-002 SHALL provide parameter WORDS_PER_PACKET, default 4, words per packet (legal range >=2).
REQ-003 SHALL provide parameter MSB_FIRST, default 0, word ordering (0: first word in LS slot; 1: first word in MS slot).
REQ-004 SHALL provide parameter TIMEOUT, default 0, inter-word idle limit in cycles (0 disables the limit).
REQ-005 SHALL provide port clk, input, 1, clock; all logic on the rising edge.
REQ-006 SHALL provide port n_reset, input, 1, synchronous, active-low reset.
REQ-007 SHALL provide port in_data, input, WORD_SIZE, input word.
REQ-008 SHALL provide port in_valid, input, 1, in_data valid this cycle.
REQ-009 SHALL provide port in_ready, output, 1, block can accept a word this cycle.
REQ-010 SHALL provide port out_data, output, WORD_SIZE*WORDS_PER_PACKET, assembled packet.
REQ-011 SHALL provide port out_valid, output, 1, out_data holds a packet.
REQ-012 SHALL provide port out_ready, input, 1, downstream accepts the packet.
REQ-013 SHALL provide port timeout_pulse, output, 1, one-cycle strobe on partial-packet discard.
REQ-014 SHALL provide port overflow, output, 1, sticky flag for a dropped input word.
REQ-015 SHALL provide port clr_err, input, 1, clears overflow.

Function
REQ-016 SHALL accept a word when in_valid && in_ready; word k (0 = first of packet) goes to slot k (MSB_FIRST=0) or slot N-1-k (MSB_FIRST=1); slot s = out_data bits [(s+1)*WORD_SIZE-1 : s*WORD_SIZE].
REQ-017 SHALL hold a word counter of width $clog2(WORDS_PER_PACKET)+1; counter clears to 0 on acceptance of word N-1.
REQ-018 SHALL contain one assembly buffer and one output register (double buffering).
REQ-019 On the edge accepting word N-1: if output register is empty, or out_valid && out_ready that cycle, SHALL load the complete packet into the output register, out_valid=1 from the next cycle, and in_ready stays 1.
REQ-020 Otherwise SHALL mark the assembly buffer pending and drive in_ready=0 until pending is transferred.
REQ-021 On the edge where out_valid && out_ready with pending set, SHALL move pending into the output register, keep out_valid=1, clear pending, and drive in_ready=1 from the next cycle.
REQ-022 On out_valid && out_ready with nothing pending and no completing word, SHALL drop out_valid to 0 on the next cycle.
REQ-023 SHALL hold out_data and out_valid stable while out_valid && !out_ready.
REQ-024 When in_valid && !in_ready, SHALL discard the word, leave the assembly buffer unchanged, and set overflow=1 on the next cycle.
REQ-025 SHALL clear overflow when clr_err=1; a simultaneous set takes priority, so overflow stays 1.
REQ-026 When TIMEOUT>0, SHALL count consecutive cycles with counter in 1..N-1 and no accepted word; the count restarts on every accepted word.
REQ-027 When that count reaches TIMEOUT, SHALL clear the word counter and discard the partial packet; timeout_pulse=1 for exactly the following cycle.
REQ-028 SHALL give an accepted word priority over timeout expiry in the same cycle; no discard occurs.
REQ-029 SHALL never assert timeout_pulse while pending is set or the counter is 0, and never when TIMEOUT=0.
REQ-030 SHALL produce a minimum latency of 1 cycle from acceptance of the last word to out_valid; sustained throughput SHALL be one word per cycle.

Reset
REQ-031 While n_reset=0 at a clock edge, SHALL clear counter, timeout counter, pending, out_valid, timeout_pulse, overflow and out_data to 0.
REQ-032 SHALL drive in_ready=1 from the first cycle after reset.
REQ-033 A reset mid-packet SHALL discard all partial and pending data.

Verification (W=8, N=4)
REQ-034 MSB_FIRST=0, out_ready=1, words 11,22,33,44 on consecutive cycles -> out_data=0x44332211, out_valid high exactly 1 cycle, 1 cycle after word 44.
REQ-035 MSB_FIRST=1, same stimulus -> out_data=0x11223344.
REQ-036 out_ready=0, 8 words then a 9th -> in_ready=0 after the 8th, 9th dropped, overflow=1; then out_ready=1 -> packet 1 and packet 2 on consecutive cycles, then in_ready=1.
REQ-037 TIMEOUT=16, 2 words then 16 idle cycles -> timeout_pulse for 1 cycle; next words AA,BB,CC,DD -> out_data=0xDDCCBBAA.
REQ-038 n_reset=0 after 3 accepted words -> all outputs 0; next 4 words form a clean packet.
REQ-039 clr_err=1 in the same cycle as a dropped word -> overflow remains 1; clr_err alone the next cycle -> overflow=0.

Source files
------------

// File: rtl/msg_asm_stream.sv
// Packs WORDS_PER_PACKET input words into one wide packet, with a double-buffered
// output stage, an optional inter-word idle timeout and a sticky overflow flag.
module msg_asm_stream #(
   parameter int WORD_SIZE        = 8,
   parameter int WORDS_PER_PACKET = 4,
   parameter int MSB_FIRST        = 0,
   parameter int TIMEOUT          = 0
) (
   input  logic                                  clk,
   input  logic                                  n_reset,
   input  logic [WORD_SIZE-1:0]                  in_data,
   input  logic                                  in_valid,
   output logic                                  in_ready,
   output logic [WORD_SIZE*WORDS_PER_PACKET-1:0] out_data,
   output logic                                  out_valid,
   input  logic                                  out_ready,
   output logic                                  timeout_pulse,
   output logic                                  overflow,
   input  logic                                  clr_err
);

   localparam int N  = WORDS_PER_PACKET;
   localparam int W  = WORD_SIZE;
   localparam int CW = $clog2(N) + 1;
   localparam int TW = (TIMEOUT > 0) ? $clog2(TIMEOUT + 1) : 1;

   logic [CW-1:0]  cnt_reg;
   logic [TW-1:0]  to_cnt_reg;
   logic [N*W-1:0] asm_reg;
   logic [N*W-1:0] asm_next;
   logic [N*W-1:0] out_data_reg;
   logic           out_valid_reg;
   logic           pending_reg;
   logic           pulse_reg;
   logic           overflow_reg;

   logic accept;
   logic complete;
   logic drain;
   logic drop;
   logic expire;

   // While a full packet waits in the assembly buffer, no new word can land.
   assign in_ready = !pending_reg;
   assign accept   = in_valid && in_ready;
   assign drop     = in_valid && !in_ready;
   assign complete = accept && (cnt_reg == CW'(N - 1));
   assign drain    = out_valid_reg && out_ready;
   assign expire   = (TIMEOUT > 0) && !accept && (cnt_reg != '0) &&
                     (int'(to_cnt_reg) + 1 >= TIMEOUT);

   // asm_next is the buffer with the incoming word already placed, so a completing
   // word can go straight to the output register on the same edge.
   genvar gi;
   generate
      for (gi = 0; gi < N; gi++) begin : g_slot
         localparam int K = (MSB_FIRST != 0) ? (N - 1 - gi) : gi;
         assign asm_next[gi*W +: W] = (accept && (cnt_reg == CW'(K))) ?
                                      in_data : asm_reg[gi*W +: W];
      end
   endgenerate

   always_ff @(posedge clk) begin
      if (!n_reset) begin
         cnt_reg       <= '0;
         to_cnt_reg    <= '0;
         asm_reg       <= '0;
         out_data_reg  <= '0;
         out_valid_reg <= 1'b0;
         pending_reg   <= 1'b0;
         pulse_reg     <= 1'b0;
         overflow_reg  <= 1'b0;
      end else begin
         pulse_reg <= expire;

         if (drop)
            overflow_reg <= 1'b1;
         else if (clr_err)
            overflow_reg <= 1'b0;

         if (accept) begin
            asm_reg    <= asm_next;
            cnt_reg    <= complete ? '0 : cnt_reg + CW'(1);
            to_cnt_reg <= '0;
         end else if (expire) begin
            cnt_reg    <= '0;
            to_cnt_reg <= '0;
         end else if ((TIMEOUT > 0) && (cnt_reg != '0)) begin
            to_cnt_reg <= to_cnt_reg + TW'(1);
         end else begin
            to_cnt_reg <= '0;
         end

         if (pending_reg && drain) begin
            out_data_reg <= asm_reg;
            pending_reg  <= 1'b0;
         end else if (complete && (!out_valid_reg || drain)) begin
            out_data_reg  <= asm_next;
            out_valid_reg <= 1'b1;
         end else if (complete) begin
            pending_reg <= 1'b1;
         end else if (drain) begin
            out_valid_reg <= 1'b0;
         end
      end
   end

   assign out_data      = out_data_reg;
   assign out_valid     = out_valid_reg;
   assign timeout_pulse = pulse_reg;
   assign overflow      = overflow_reg;

endmodule

// File: tb/tb_msg_asm_stream.sv
// Directed bench: dut0 is LS-first with a 16-cycle timeout, dut1 is MS-first with
// the timeout disabled; both see identical stimulus.
module tb_msg_asm_stream;

   logic        clk = 1'b0;
   logic        n_reset = 1'b0;
   logic [7:0]  in_data = '0;
   logic        in_valid = 1'b0;
   logic        out_ready = 1'b0;
   logic        clr_err = 1'b0;

   logic        in_ready0, out_valid0, pulse0, overflow0;
   logic [31:0] out_data0;
   logic        in_ready1, out_valid1, pulse1, overflow1;
   logic [31:0] out_data1;

   int checks = 0;
   int errors = 0;

   always #5 clk = ~clk;

   msg_asm_stream #(.WORD_SIZE(8), .WORDS_PER_PACKET(4), .MSB_FIRST(0), .TIMEOUT(16)) dut0 (
      .clk(clk), .n_reset(n_reset), .in_data(in_data), .in_valid(in_valid),
      .in_ready(in_ready0), .out_data(out_data0), .out_valid(out_valid0),
      .out_ready(out_ready), .timeout_pulse(pulse0), .overflow(overflow0), .clr_err(clr_err)
   );

   msg_asm_stream #(.WORD_SIZE(8), .WORDS_PER_PACKET(4), .MSB_FIRST(1), .TIMEOUT(0)) dut1 (
      .clk(clk), .n_reset(n_reset), .in_data(in_data), .in_valid(in_valid),
      .in_ready(in_ready1), .out_data(out_data1), .out_valid(out_valid1),
      .out_ready(out_ready), .timeout_pulse(pulse1), .overflow(overflow1), .clr_err(clr_err)
   );

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic send_word(input logic [7:0] d);
      in_data  = d;
      in_valid = 1'b1;
      step();
      in_valid = 1'b0;
      $display("word %h: out_valid=%0b out_data=%h in_ready=%0b overflow=%0b",
               d, out_valid0, out_data0, in_ready0, overflow0);
   endtask

   task automatic test_reset();
      n_reset = 1'b0;
      step();
      step();
      checks++;
      if (out_valid0 !== 1'b0 || out_data0 !== 32'h0 || overflow0 !== 1'b0 || pulse0 !== 1'b0) begin
         errors++;
         $display("FAIL reset_outputs: got valid=%b data=%h ovf=%b pulse=%b required 0", out_valid0, out_data0, overflow0, pulse0);
      end
      n_reset = 1'b1;
      step();
      checks++;
      if (in_ready0 !== 1'b1) begin
         errors++;
         $display("FAIL reset_in_ready: got %b required 1", in_ready0);
      end
   endtask

   task automatic test_ordering();
      out_ready = 1'b1;
      send_word(8'h11);
      send_word(8'h22);
      send_word(8'h33);
      checks++;
      if (out_valid0 !== 1'b0) begin
         errors++;
         $display("FAIL early_valid: got %b required 0", out_valid0);
      end
      send_word(8'h44);
      checks++;
      if (out_valid0 !== 1'b1 || out_data0 !== 32'h44332211) begin
         errors++;
         $display("FAIL lsb_first: got valid=%b data=%h required 1/44332211", out_valid0, out_data0);
      end
      checks++;
      if (out_valid1 !== 1'b1 || out_data1 !== 32'h11223344) begin
         errors++;
         $display("FAIL msb_first: got valid=%b data=%h required 1/11223344", out_valid1, out_data1);
      end
      step();
      checks++;
      if (out_valid0 !== 1'b0 || out_valid1 !== 1'b0) begin
         errors++;
         $display("FAIL valid_one_cycle: got %b/%b required 0/0", out_valid0, out_valid1);
      end
   endtask

   task automatic test_back_to_back();
      out_ready = 1'b1;
      for (int i = 0; i < 4; i++) send_word(8'h81 + 8'(i));
      checks++;
      if (out_valid0 !== 1'b1 || out_data0 !== 32'h84838281) begin
         errors++;
         $display("FAIL b2b_pkt1: got valid=%b data=%h required 1/84838281", out_valid0, out_data0);
      end
      send_word(8'h85);
      checks++;
      if (out_valid0 !== 1'b0 || in_ready0 !== 1'b1) begin
         errors++;
         $display("FAIL b2b_gap: got valid=%b ready=%b required 0/1", out_valid0, in_ready0);
      end
      for (int i = 1; i < 4; i++) send_word(8'h85 + 8'(i));
      checks++;
      if (out_valid0 !== 1'b1 || out_data0 !== 32'h88878685) begin
         errors++;
         $display("FAIL b2b_pkt2: got valid=%b data=%h required 1/88878685", out_valid0, out_data0);
      end
      step();
   endtask

   task automatic test_overflow();
      out_ready = 1'b0;
      for (int i = 0; i < 4; i++) send_word(8'h01 + 8'(i));
      checks++;
      if (out_valid0 !== 1'b1 || out_data0 !== 32'h04030201 || in_ready0 !== 1'b1) begin
         errors++;
         $display("FAIL ovf_pkt1: got valid=%b data=%h ready=%b required 1/04030201/1", out_valid0, out_data0, in_ready0);
      end
      for (int i = 4; i < 8; i++) send_word(8'h01 + 8'(i));
      checks++;
      if (in_ready0 !== 1'b0) begin
         errors++;
         $display("FAIL ovf_backpressure: got ready=%b required 0", in_ready0);
      end
      send_word(8'h09);
      checks++;
      if (overflow0 !== 1'b1 || out_data0 !== 32'h04030201 || out_valid0 !== 1'b1) begin
         errors++;
         $display("FAIL ovf_drop: got ovf=%b data=%h valid=%b required 1/04030201/1", overflow0, out_data0, out_valid0);
      end
      out_ready = 1'b1;
      step();
      checks++;
      if (out_valid0 !== 1'b1 || out_data0 !== 32'h08070605 || in_ready0 !== 1'b1) begin
         errors++;
         $display("FAIL ovf_pkt2: got valid=%b data=%h ready=%b required 1/08070605/1", out_valid0, out_data0, in_ready0);
      end
      checks++;
      if (out_data1 !== 32'h05060708) begin
         errors++;
         $display("FAIL ovf_pkt2_msb: got %h required 05060708", out_data1);
      end
      step();
      checks++;
      if (out_valid0 !== 1'b0) begin
         errors++;
         $display("FAIL ovf_drained: got valid=%b required 0", out_valid0);
      end
   endtask

   task automatic test_clr_err();
      clr_err = 1'b1;
      step();
      clr_err = 1'b0;
      checks++;
      if (overflow0 !== 1'b0) begin
         errors++;
         $display("FAIL clr_plain: got %b required 0", overflow0);
      end
      out_ready = 1'b0;
      for (int i = 0; i < 8; i++) send_word(8'hC1 + 8'(i));
      clr_err = 1'b1;
      send_word(8'hFF);
      checks++;
      if (overflow0 !== 1'b1) begin
         errors++;
         $display("FAIL clr_vs_set: got %b required 1", overflow0);
      end
      step();
      clr_err = 1'b0;
      checks++;
      if (overflow0 !== 1'b0) begin
         errors++;
         $display("FAIL clr_after: got %b required 0", overflow0);
      end
      out_ready = 1'b1;
      step();
      checks++;
      if (out_data0 !== 32'hC8C7C6C5) begin
         errors++;
         $display("FAIL clr_pkt2: got %h required c8c7c6c5", out_data0);
      end
      step();
   endtask

   task automatic test_timeout();
      out_ready = 1'b1;
      send_word(8'h01);
      send_word(8'h02);
      for (int i = 1; i <= 17; i++) begin
         step();
         checks++;
         if (pulse0 !== (i == 16) || pulse1 !== 1'b0) begin
            errors++;
            $display("FAIL timeout_pulse[%0d]: got %b/%b required %b/0", i, pulse0, pulse1, (i == 16));
         end
      end
      send_word(8'hAA);
      send_word(8'hBB);
      send_word(8'hCC);
      send_word(8'hDD);
      checks++;
      if (out_valid0 !== 1'b1 || out_data0 !== 32'hDDCCBBAA) begin
         errors++;
         $display("FAIL timeout_repack: got valid=%b data=%h required 1/ddccbbaa", out_valid0, out_data0);
      end
      step();
   endtask

   task automatic test_timeout_priority();
      out_ready = 1'b1;
      send_word(8'h10);
      for (int i = 0; i < 15; i++) step();
      send_word(8'h20);
      checks++;
      if (pulse0 !== 1'b0) begin
         errors++;
         $display("FAIL prio_pulse: got %b required 0", pulse0);
      end
      send_word(8'h30);
      send_word(8'h40);
      checks++;
      if (out_valid0 !== 1'b1 || out_data0 !== 32'h40302010) begin
         errors++;
         $display("FAIL prio_packet: got valid=%b data=%h required 1/40302010", out_valid0, out_data0);
      end
      step();
   endtask

   task automatic test_reset_mid();
      out_ready = 1'b1;
      send_word(8'h61);
      send_word(8'h62);
      send_word(8'h63);
      n_reset = 1'b0;
      step();
      checks++;
      if (out_valid0 !== 1'b0 || out_data0 !== 32'h0 || overflow0 !== 1'b0 || pulse0 !== 1'b0) begin
         errors++;
         $display("FAIL midreset_outputs: got valid=%b data=%h ovf=%b pulse=%b required 0", out_valid0, out_data0, overflow0, pulse0);
      end
      n_reset = 1'b1;
      for (int i = 0; i < 4; i++) send_word(8'h71 + 8'(i));
      checks++;
      if (out_valid0 !== 1'b1 || out_data0 !== 32'h74737271) begin
         errors++;
         $display("FAIL midreset_packet: got valid=%b data=%h required 1/74737271", out_valid0, out_data0);
      end
      step();
   endtask

   initial begin
      test_reset();
      test_ordering();
      test_back_to_back();
      test_overflow();
      test_clr_err();
      test_timeout();
      test_timeout_priority();
      test_reset_mid();
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
